// File: rtl/scr1_tapc_pkg.sv
// Shared definitions for the SCR1 JTAG TAP controller.
// Holds the TAP state encoding, the default IR width and the IR opcodes
// that the TAP controller recognises.
package scr1_tapc_pkg;

    // Default instruction register width in bits
    localparam int SCR1_TAP_IR_WIDTH_DFLT = 5;

    // IR opcodes. Any opcode not listed here selects the internal bypass register.
    localparam logic [4:0] SCR1_TAP_INSTR_IDCODE = 5'h01;
    localparam logic [4:0] SCR1_TAP_INSTR_DTMCS  = 5'h10;
    localparam logic [4:0] SCR1_TAP_INSTR_DMI    = 5'h11;
    localparam logic [4:0] SCR1_TAP_INSTR_BYPASS = 5'h1F;

    // IEEE 1149.1 TAP state encoding
    typedef logic [3:0] type_scr1_tap_state_e;

    localparam type_scr1_tap_state_e SCR1_TAP_STATE_TLR    = 4'd0;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_RTI    = 4'd1;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_SEL_DR = 4'd2;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_CAP_DR = 4'd3;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_SH_DR  = 4'd4;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_EX1_DR = 4'd5;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_PA_DR  = 4'd6;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_EX2_DR = 4'd7;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_UPD_DR = 4'd8;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_SEL_IR = 4'd9;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_CAP_IR = 4'd10;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_SH_IR  = 4'd11;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_EX1_IR = 4'd12;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_PA_IR  = 4'd13;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_EX2_IR = 4'd14;
    localparam type_scr1_tap_state_e SCR1_TAP_STATE_UPD_IR = 4'd15;

endpackage : scr1_tapc_pkg

// File: rtl/scr1_tapc_data_reg.sv
// Generic JTAG data register: a serial shift register plus a parallel shadow.
// The shift part captures/shifts on the rising edge of TCK, the shadow is
// updated on the falling edge, as required for JTAG update semantics.
// Ports:
//   i_clk, i_rst_n     - TCK and asynchronous active-low reset
//   i_tlr              - high while the TAP is in Test-Logic-Reset (sync reload)
//   i_select           - register is the currently selected one
//   i_capture/i_shift/i_update - TAP control strobes
//   i_tdi              - serial input
//   i_din_parallel     - value loaded on capture
//   o_dout_parallel    - shadow value
//   o_dout_serial      - LSB of the shift register (serial output)
module scr1_tapc_data_reg #(
    parameter int                 WIDTH       = 5,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tlr,
    input  logic             i_select,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_update,
    input  logic             i_tdi,
    input  logic [WIDTH-1:0] i_din_parallel,
    output logic [WIDTH-1:0] o_dout_parallel,
    output logic             o_dout_serial
);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_shadow;

    // Shift register: reload in TLR, capture parallel data, or shift LSB-first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= RESET_VALUE;
        end else if (i_tlr) begin
            r_shift <= RESET_VALUE;
        end else if (i_select && i_capture) begin
            r_shift <= i_din_parallel;
        end else if (i_select && i_shift) begin
            r_shift <= {i_tdi, r_shift[WIDTH-1:1]};
        end
    end

    // Shadow register updates on the falling edge so it is stable for the next TCK
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= RESET_VALUE;
        end else if (i_tlr) begin
            r_shadow <= RESET_VALUE;
        end else if (i_select && i_update) begin
            r_shadow <= r_shift;
        end
    end

    assign o_dout_parallel = r_shadow;
    assign o_dout_serial   = r_shift[0];

endmodule : scr1_tapc_data_reg

// File: rtl/scr1_tapc_fsm.sv
// SCR1 JTAG TAP controller: 16-state IEEE 1149.1 FSM, instruction register,
// DR select decode, bypass register and TDO output stage.
// Ports:
//   clk, rst_n                  - TCK (both edges used) and async active-low reset
//   tms, tdi                    - JTAG inputs
//   tdo, tdo_en                 - JTAG output and its enable, registered on negedge
//   tap_rst_n_sync              - low while in Test-Logic-Reset, resets all DRs
//   fsm_dr_capture/shift/update - DR control strobes
//   dr_sel_idcode/dtmcs/dmi     - one-hot DR selects (all low selects bypass)
//   dr_tdo_idcode/dtmcs/dmi     - serial outputs of the external DRs
//   ir_value                    - current IR shadow value
module scr1_tapc_fsm
    import scr1_tapc_pkg::*;
#(
    parameter int                         SCR1_IR_WIDTH = SCR1_TAP_IR_WIDTH_DFLT,
    parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_RESET = 5'h01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic                     tap_rst_n_sync,
    output logic                     fsm_dr_capture,
    output logic                     fsm_dr_shift,
    output logic                     fsm_dr_update,
    output logic                     dr_sel_idcode,
    output logic                     dr_sel_dtmcs,
    output logic                     dr_sel_dmi,
    input  logic                     dr_tdo_idcode,
    input  logic                     dr_tdo_dtmcs,
    input  logic                     dr_tdo_dmi,
    output logic [SCR1_IR_WIDTH-1:0] ir_value
);

    // Value captured into the IR in CAP_IR: LSB pattern 01 as the standard requires
    localparam logic [SCR1_IR_WIDTH-1:0] IR_CAPTURE_VAL = {{(SCR1_IR_WIDTH-1){1'b0}}, 1'b1};

    type_scr1_tap_state_e r_state;
    type_scr1_tap_state_e w_state_next;

    logic w_tlr;
    logic w_ir_capture;
    logic w_ir_shift;
    logic w_ir_update;
    logic w_ir_tdo;
    logic w_dr_tdo;
    logic r_bypass;

    // TAP state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCR1_TAP_STATE_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Standard 1149.1 transitions driven by TMS
    always_comb begin
        w_state_next = SCR1_TAP_STATE_TLR;
        case (r_state)
            SCR1_TAP_STATE_TLR:    w_state_next = tms ? SCR1_TAP_STATE_TLR    : SCR1_TAP_STATE_RTI;
            SCR1_TAP_STATE_RTI:    w_state_next = tms ? SCR1_TAP_STATE_SEL_DR : SCR1_TAP_STATE_RTI;
            SCR1_TAP_STATE_SEL_DR: w_state_next = tms ? SCR1_TAP_STATE_SEL_IR : SCR1_TAP_STATE_CAP_DR;
            SCR1_TAP_STATE_CAP_DR: w_state_next = tms ? SCR1_TAP_STATE_EX1_DR : SCR1_TAP_STATE_SH_DR;
            SCR1_TAP_STATE_SH_DR:  w_state_next = tms ? SCR1_TAP_STATE_EX1_DR : SCR1_TAP_STATE_SH_DR;
            SCR1_TAP_STATE_EX1_DR: w_state_next = tms ? SCR1_TAP_STATE_UPD_DR : SCR1_TAP_STATE_PA_DR;
            SCR1_TAP_STATE_PA_DR:  w_state_next = tms ? SCR1_TAP_STATE_EX2_DR : SCR1_TAP_STATE_PA_DR;
            SCR1_TAP_STATE_EX2_DR: w_state_next = tms ? SCR1_TAP_STATE_UPD_DR : SCR1_TAP_STATE_SH_DR;
            SCR1_TAP_STATE_UPD_DR: w_state_next = tms ? SCR1_TAP_STATE_SEL_DR : SCR1_TAP_STATE_RTI;
            SCR1_TAP_STATE_SEL_IR: w_state_next = tms ? SCR1_TAP_STATE_TLR    : SCR1_TAP_STATE_CAP_IR;
            SCR1_TAP_STATE_CAP_IR: w_state_next = tms ? SCR1_TAP_STATE_EX1_IR : SCR1_TAP_STATE_SH_IR;
            SCR1_TAP_STATE_SH_IR:  w_state_next = tms ? SCR1_TAP_STATE_EX1_IR : SCR1_TAP_STATE_SH_IR;
            SCR1_TAP_STATE_EX1_IR: w_state_next = tms ? SCR1_TAP_STATE_UPD_IR : SCR1_TAP_STATE_PA_IR;
            SCR1_TAP_STATE_PA_IR:  w_state_next = tms ? SCR1_TAP_STATE_EX2_IR : SCR1_TAP_STATE_PA_IR;
            SCR1_TAP_STATE_EX2_IR: w_state_next = tms ? SCR1_TAP_STATE_UPD_IR : SCR1_TAP_STATE_SH_IR;
            SCR1_TAP_STATE_UPD_IR: w_state_next = tms ? SCR1_TAP_STATE_SEL_DR : SCR1_TAP_STATE_RTI;
            default:               w_state_next = SCR1_TAP_STATE_TLR;
        endcase
    end

    assign w_tlr          = (r_state == SCR1_TAP_STATE_TLR);
    assign w_ir_capture   = (r_state == SCR1_TAP_STATE_CAP_IR);
    assign w_ir_shift     = (r_state == SCR1_TAP_STATE_SH_IR);
    assign w_ir_update    = (r_state == SCR1_TAP_STATE_UPD_IR);

    assign tap_rst_n_sync = ~w_tlr;
    assign fsm_dr_capture = (r_state == SCR1_TAP_STATE_CAP_DR);
    assign fsm_dr_shift   = (r_state == SCR1_TAP_STATE_SH_DR);
    assign fsm_dr_update  = (r_state == SCR1_TAP_STATE_UPD_DR);

    // The IR is always selected; the FSM strobes alone decide when it acts
    scr1_tapc_data_reg #(
        .WIDTH       (SCR1_IR_WIDTH),
        .RESET_VALUE (SCR1_IR_RESET)
    ) i_ir_reg (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_tlr           (w_tlr),
        .i_select        (1'b1),
        .i_capture       (w_ir_capture),
        .i_shift         (w_ir_shift),
        .i_update        (w_ir_update),
        .i_tdi           (tdi),
        .i_din_parallel  (IR_CAPTURE_VAL),
        .o_dout_parallel (ir_value),
        .o_dout_serial   (w_ir_tdo)
    );

    assign dr_sel_idcode = (ir_value == SCR1_IR_WIDTH'(SCR1_TAP_INSTR_IDCODE));
    assign dr_sel_dtmcs  = (ir_value == SCR1_IR_WIDTH'(SCR1_TAP_INSTR_DTMCS));
    assign dr_sel_dmi    = (ir_value == SCR1_IR_WIDTH'(SCR1_TAP_INSTR_DMI));

    // Bypass register: one bit of delay for any unrecognised instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bypass <= 1'b0;
        end else if (fsm_dr_capture) begin
            r_bypass <= 1'b0;
        end else if (fsm_dr_shift) begin
            r_bypass <= tdi;
        end
    end

    // Serial bit of whichever DR the current instruction selects
    always_comb begin
        w_dr_tdo = r_bypass;
        if (dr_sel_idcode) begin
            w_dr_tdo = dr_tdo_idcode;
        end else if (dr_sel_dtmcs) begin
            w_dr_tdo = dr_tdo_dtmcs;
        end else if (dr_sel_dmi) begin
            w_dr_tdo = dr_tdo_dmi;
        end
    end

    // TDO stage on the falling edge; the last driven bit is held outside shift states
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= w_ir_shift | fsm_dr_shift;
            if (w_ir_shift) begin
                tdo <= w_ir_tdo;
            end else if (fsm_dr_shift) begin
                tdo <= w_dr_tdo;
            end
        end
    end

endmodule : scr1_tapc_fsm

// File: tb/tb_scr1_tapc_fsm.sv
// Self-checking testbench for scr1_tapc_fsm.
// A table of TMS walks reaches each of the 16 TAP states and checks the
// observable strobes there, then returns to Test-Logic-Reset with five TMS=1.
// Hand-written sequences cover IR load, bypass, IDCODE DR access and async reset.
module tb_scr1_tapc_fsm;

    logic       clk = 1'b0;
    logic       rstN;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdoEn;
    logic       tapRstNSync;
    logic       drCapture;
    logic       drShift;
    logic       drUpdate;
    logic       selIdcode;
    logic       selDtmcs;
    logic       selDmi;
    logic       tdoIdcode;
    logic       tdoDtmcs;
    logic       tdoDmi;
    logic [4:0] irValue;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] tmsSeq;
        int         len;
        logic [4:0] expOut;
    } walkVec_t;

    walkVec_t walkTab[16];

    scr1_tapc_fsm dut (
        .clk            (clk),
        .rst_n          (rstN),
        .tms            (tms),
        .tdi            (tdi),
        .tdo            (tdo),
        .tdo_en         (tdoEn),
        .tap_rst_n_sync (tapRstNSync),
        .fsm_dr_capture (drCapture),
        .fsm_dr_shift   (drShift),
        .fsm_dr_update  (drUpdate),
        .dr_sel_idcode  (selIdcode),
        .dr_sel_dtmcs   (selDtmcs),
        .dr_sel_dmi     (selDmi),
        .dr_tdo_idcode  (tdoIdcode),
        .dr_tdo_dtmcs   (tdoDtmcs),
        .dr_tdo_dmi     (tdoDmi),
        .ir_value       (irValue)
    );

    // TCK: posedges at 5, 15, 25 ...; negedges at 10, 20, 30 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive TMS/TDI, then let one full TCK pass and sample 1 time unit after the negedge
    task automatic applyStimulus(input logic tmsVal, input logic tdiVal);
        tms = tmsVal;
        tdi = tdiVal;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic goTlr();
        repeat (5) applyStimulus(1'b1, 1'b0);
    endtask

    // Load IR with v (LSB first) and finish in RTI; checks the captured 00001 coming out on TDO
    task automatic loadIr(input logic [4:0] v, input string tag);
        logic [4:0] capVal;
        capVal = 5'b00001;
        goTlr();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_irTdo0"}, 32'(tdo), 32'(capVal[0]));
        checkOutput({tag, "_irTdoEn"}, 32'(tdoEn), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, v[i]);
            if (i < 4) begin
                checkOutput($sformatf("%s_irTdo%0d", tag, i + 1), 32'(tdo), 32'(capVal[i+1]));
            end
        end
        checkOutput({tag, "_irBeforeUpd"}, 32'(irValue), 32'h01);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, "_irAfterUpd"}, 32'(irValue), 32'(v));
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pattern;
        logic [3:0] idBits;

        walkTab[0]  = '{"TLR",    8'h00, 0, 5'b00000};
        walkTab[1]  = '{"RTI",    8'h00, 1, 5'b10000};
        walkTab[2]  = '{"SEL_DR", 8'h02, 2, 5'b10000};
        walkTab[3]  = '{"CAP_DR", 8'h02, 3, 5'b11000};
        walkTab[4]  = '{"SH_DR",  8'h02, 4, 5'b10101};
        walkTab[5]  = '{"EX1_DR", 8'h0A, 4, 5'b10000};
        walkTab[6]  = '{"PA_DR",  8'h0A, 5, 5'b10000};
        walkTab[7]  = '{"EX2_DR", 8'h2A, 6, 5'b10000};
        walkTab[8]  = '{"UPD_DR", 8'h1A, 5, 5'b10010};
        walkTab[9]  = '{"SEL_IR", 8'h06, 3, 5'b10000};
        walkTab[10] = '{"CAP_IR", 8'h06, 4, 5'b10000};
        walkTab[11] = '{"SH_IR",  8'h06, 5, 5'b10001};
        walkTab[12] = '{"EX1_IR", 8'h16, 5, 5'b10000};
        walkTab[13] = '{"PA_IR",  8'h16, 6, 5'b10000};
        walkTab[14] = '{"EX2_IR", 8'h56, 7, 5'b10000};
        walkTab[15] = '{"UPD_IR", 8'h36, 6, 5'b10000};

        rstN      = 1'b0;
        tms       = 1'b1;
        tdi       = 1'b0;
        tdoIdcode = 1'b0;
        tdoDtmcs  = 1'b0;
        tdoDmi    = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_tapRstNSync", 32'(tapRstNSync), 32'd0);
        checkOutput("rst_tdo", 32'(tdo), 32'd0);
        checkOutput("rst_tdoEn", 32'(tdoEn), 32'd0);
        checkOutput("rst_irValue", 32'(irValue), 32'h01);
        checkOutput("rst_strobes", 32'({drCapture, drShift, drUpdate}), 32'd0);
        checkOutput("rst_selIdcode", 32'(selIdcode), 32'd1);
        rstN = 1'b1;
        #1;
        checkOutput("postRst_tapRstNSync", 32'(tapRstNSync), 32'd0);

        // Load DTMCS, then five TMS=1 must land in TLR with IR reloaded to IDCODE
        loadIr(5'h10, "dtmcs");
        checkOutput("dtmcs_sel", 32'({selIdcode, selDtmcs, selDmi}), 32'b010);
        goTlr();
        checkOutput("tlr_irValue", 32'(irValue), 32'h01);
        checkOutput("tlr_tapRstNSync", 32'(tapRstNSync), 32'd0);
        checkOutput("tlr_tdoEn", 32'(tdoEn), 32'd0);
        checkOutput("tlr_selIdcode", 32'(selIdcode), 32'd1);

        // Load DMI: TDO during IR shift is 1,0,0,0,0 and dr_sel_dmi follows UPD_IR
        loadIr(5'h11, "dmi");
        checkOutput("dmi_sel", 32'({selIdcode, selDtmcs, selDmi}), 32'b001);

        // BYPASS: 8 DR bits come back delayed by one bit behind a leading 0
        loadIr(5'h1F, "byp");
        checkOutput("byp_sel", 32'({selIdcode, selDtmcs, selDmi}), 32'b000);
        pattern = 8'hA5;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("byp_tdoFirst", 32'(tdo), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, pattern[i]);
            checkOutput($sformatf("byp_tdo%0d", i), 32'(tdo), 32'(pattern[i]));
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // IDCODE DR: capture strobe one cycle, TDO follows dr_tdo_idcode, tdo_en low in PA_DR
        loadIr(5'h01, "idc");
        checkOutput("idc_sel", 32'({selIdcode, selDtmcs, selDmi}), 32'b100);
        idBits = 4'b1011;
        applyStimulus(1'b1, 1'b0);
        checkOutput("idc_capSelDr", 32'(drCapture), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("idc_capCapDr", 32'(drCapture), 32'd1);
        checkOutput("idc_shiftCapDr", 32'(drShift), 32'd0);
        tdoIdcode = idBits[0];
        tdoDtmcs  = ~idBits[0];
        tdoDmi    = ~idBits[0];
        applyStimulus(1'b0, 1'b0);
        checkOutput("idc_capShDr", 32'(drCapture), 32'd0);
        checkOutput("idc_shiftShDr", 32'(drShift), 32'd1);
        checkOutput("idc_tdoEnShDr", 32'(tdoEn), 32'd1);
        checkOutput("idc_tdo0", 32'(tdo), 32'(idBits[0]));
        for (int i = 1; i < 4; i++) begin
            tdoIdcode = idBits[i];
            tdoDtmcs  = ~idBits[i];
            tdoDmi    = ~idBits[i];
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("idc_tdo%0d", i), 32'(tdo), 32'(idBits[i]));
        end
        tdoIdcode = ~idBits[3];
        applyStimulus(1'b1, 1'b0);
        checkOutput("idc_tdoEnEx1", 32'(tdoEn), 32'd0);
        checkOutput("idc_tdoHoldEx1", 32'(tdo), 32'(idBits[3]));
        applyStimulus(1'b0, 1'b0);
        checkOutput("idc_tdoEnPaDr", 32'(tdoEn), 32'd0);
        checkOutput("idc_tdoHoldPaDr", 32'(tdo), 32'(idBits[3]));
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("idc_updUpdDr", 32'(drUpdate), 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("idc_updRti", 32'(drUpdate), 32'd0);

        // Async reset in the middle of SH_DR
        loadIr(5'h11, "ar");
        tdoDmi = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ar_tdoBefore", 32'(tdo), 32'd1);
        checkOutput("ar_tdoEnBefore", 32'(tdoEn), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_tapRstNSync", 32'(tapRstNSync), 32'd0);
        checkOutput("ar_tdo", 32'(tdo), 32'd0);
        checkOutput("ar_tdoEn", 32'(tdoEn), 32'd0);
        checkOutput("ar_irValue", 32'(irValue), 32'h01);
        checkOutput("ar_strobes", 32'({drCapture, drShift, drUpdate}), 32'd0);
        @(negedge clk);
        #1;
        rstN   = 1'b1;
        tdoDmi = 1'b0;

        // Reach every state from TLR, check it, then TMS=1 x5 back to TLR
        for (int v = 0; v < 16; v++) begin
            goTlr();
            for (int k = 0; k < walkTab[v].len; k++) begin
                applyStimulus(walkTab[v].tmsSeq[k], 1'b0);
            end
            checkOutput({"walk_", walkTab[v].name},
                        32'({tapRstNSync, drCapture, drShift, drUpdate, tdoEn}),
                        32'(walkTab[v].expOut));
            goTlr();
            checkOutput({"walkTlr_", walkTab[v].name},
                        32'({tapRstNSync, drCapture, drShift, drUpdate}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_scr1_tapc_fsm
